// File: rtl/seven_seg_pkg.sv
// Shared segment patterns (active-low, {g,f,e,d,c,b,a}) and scan state type
// for the seven-segment scan driver.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        GUARD = 1'b0,
        SCAN  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble-to-segment decoder producing active-low patterns;
// codes 10-15 are blanked unless hex display is enabled.
module seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       hex_en_i,
    output logic [6:0] seg_o
);

    logic [6:0] raw_s;

    // Raw glyph lookup for every nibble value
    always_comb begin
        raw_s = SEG_BLANK;
        case (code_i)
            4'h0:    raw_s = SEG_0;
            4'h1:    raw_s = SEG_1;
            4'h2:    raw_s = SEG_2;
            4'h3:    raw_s = SEG_3;
            4'h4:    raw_s = SEG_4;
            4'h5:    raw_s = SEG_5;
            4'h6:    raw_s = SEG_6;
            4'h7:    raw_s = SEG_7;
            4'h8:    raw_s = SEG_8;
            4'h9:    raw_s = SEG_9;
            4'hA:    raw_s = SEG_A;
            4'hB:    raw_s = SEG_B;
            4'hC:    raw_s = SEG_C;
            4'hD:    raw_s = SEG_D;
            4'hE:    raw_s = SEG_E;
            4'hF:    raw_s = SEG_F;
            default: raw_s = SEG_BLANK;
        endcase
    end

    // Suppress letters when only decimal digits are wanted
    always_comb begin
        if (!hex_en_i && (code_i > 4'd9)) begin
            seg_o = SEG_BLANK;
        end else begin
            seg_o = raw_s;
        end
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver with leading-zero
// blanking, minus-sign placement, decimal points and inter-digit guard time.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int GUARD_CYC  = 16,
    parameter int HEX_EN     = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    neg_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    sign_err
);

    localparam int TICK_RAW = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;
    localparam int CNT_MAX  = (TICK_DIV > GUARD_CYC) ? TICK_DIV : GUARD_CYC;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic INV    = (ACTIVE_LOW == 0);
    localparam logic HEX    = (HEX_EN != 0);

    localparam logic [6:0]            SEG_RST = SEG_BLANK ^ {7{INV}};
    localparam logic                  DP_RST  = 1'b1 ^ INV;
    localparam logic [NUM_DIGITS-1:0] AN_RST  = {NUM_DIGITS{1'b1 ^ INV}};
    localparam logic [NUM_DIGITS-1:0] ONE_HOT = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [4*NUM_DIGITS-1:0] dig_sh_q;
    logic [NUM_DIGITS-1:0]   dp_sh_q;
    logic                    neg_sh_q;
    scan_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    sign_err_q;

    logic [NUM_DIGITS-1:0]   blank_s;
    logic [NUM_DIGITS-1:0]   minus_s;
    logic                    zero_run_s;
    logic                    sign_err_d;
    logic [3:0]              code_s;
    logic [6:0]              dec_seg_s;
    logic [6:0]              seg_al_s;
    logic                    dp_al_s;
    logic [NUM_DIGITS-1:0]   an_al_s;

    // Shadow copy of the displayed value; only replaced as a whole on load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_sh_q <= '0;
            dp_sh_q  <= '0;
            neg_sh_q <= 1'b0;
        end else if (load) begin
            dig_sh_q <= digits_in;
            dp_sh_q  <= dp_in;
            neg_sh_q <= neg_in;
        end else begin
            dig_sh_q <= dig_sh_q;
            dp_sh_q  <= dp_sh_q;
            neg_sh_q <= neg_sh_q;
        end
    end

    // Scan state, slot counter and digit index registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= GUARD;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state: guard gap, then a TICK_DIV-long slot per digit
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CYC - 1)) begin
                    state_d = SCAN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SCAN: begin
                if (cnt_q == CNT_W'(TICK_DIV - 1)) begin
                    state_d = GUARD;
                    cnt_d   = '0;
                    idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = GUARD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Blanked digits form a contiguous run from the top; any dp stops the run
    always_comb begin
        zero_run_s = blank_lz;
        blank_s    = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run_s = zero_run_s & (dig_sh_q[4*i +: 4] == 4'd0) & ~dp_sh_q[i];
            blank_s[i] = zero_run_s;
        end
    end

    // Minus goes on the lowest blanked digit, directly above the top shown one
    always_comb begin
        minus_s = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            minus_s[i] = neg_sh_q & blank_s[i] & ~blank_s[i-1];
        end
        sign_err_d = neg_sh_q & ~blank_s[NUM_DIGITS-1];
    end

    assign code_s = dig_sh_q[{idx_q, 2'b00} +: 4];

    seg_hex_decode u_decode (
        .code_i   (code_s),
        .hex_en_i (HEX),
        .seg_o    (dec_seg_s)
    );

    // Active-low view of the outputs for the current state and digit
    always_comb begin
        seg_al_s = SEG_BLANK;
        dp_al_s  = 1'b1;
        an_al_s  = '1;
        if (state_q == SCAN) begin
            an_al_s = ~(ONE_HOT << idx_q);
            dp_al_s = ~dp_sh_q[idx_q];
            if (minus_s[idx_q]) begin
                seg_al_s = SEG_MINUS;
            end else if (blank_s[idx_q]) begin
                seg_al_s = SEG_BLANK;
            end else begin
                seg_al_s = dec_seg_s;
            end
        end else begin
            seg_al_s = SEG_BLANK;
            dp_al_s  = 1'b1;
            an_al_s  = '1;
        end
    end

    // Output registers with board polarity applied
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q      <= SEG_RST;
            dp_q       <= DP_RST;
            an_q       <= AN_RST;
            sign_err_q <= 1'b0;
        end else begin
            seg_q      <= seg_al_s ^ {7{INV}};
            dp_q       <= dp_al_s ^ INV;
            an_q       <= an_al_s ^ {NUM_DIGITS{INV}};
            sign_err_q <= sign_err_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign sign_err = sign_err_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomised and directed bench for seven_seg_scan: two instances (hex/active-low
// and decimal-only/active-high) checked every cycle against a frame-level model.
module tb_seven_seg_scan;

    localparam int N     = 4;
    localparam int GUARD = 1;
    localparam int TICK  = 4;
    localparam int SLOT  = GUARD + TICK;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        neg_in;
    logic        blank_lz;

    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  an_a, an_b;
    logic        serr_a, serr_b;

    int n_vec = 0;
    int n_bad = 0;
    int k     = 0;

    logic [15:0] m_dig;
    logic [3:0]  m_dp;
    logic        m_neg;

    logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(N), .CLK_HZ(8000), .REFRESH_HZ(500), .GUARD_CYC(GUARD),
                     .HEX_EN(1), .ACTIVE_LOW(1)) u_dut_a (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .neg_in(neg_in), .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .an(an_a),
        .sign_err(serr_a));

    seven_seg_scan #(.NUM_DIGITS(N), .CLK_HZ(8000), .REFRESH_HZ(500), .GUARD_CYC(GUARD),
                     .HEX_EN(0), .ACTIVE_LOW(0)) u_dut_b (
        .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
        .neg_in(neg_in), .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .an(an_b),
        .sign_err(serr_b));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Highest digit that stays visible; everything above it is blank
    function automatic int top_shown(input logic [15:0] d, input logic [3:0] p, input logic blz);
        if (!blz) return N - 1;
        for (int j = N - 1; j >= 1; j--) begin
            if (((d >> (4 * j)) & 16'hF) != 16'h0 || p[j]) return j;
        end
        return 0;
    endfunction

    function automatic logic [6:0] exp_seg(input int i, input bit hex, input logic [15:0] d,
                                           input logic [3:0] p, input logic ng, input logic blz);
        int t;
        logic [3:0] c;
        t = top_shown(d, p, blz);
        c = 4'(d >> (4 * i));
        if (i > t) return (ng && i == t + 1) ? 7'b0111111 : 7'b1111111;
        if (!hex && c > 4'd9) return 7'b1111111;
        return seg_tab[c];
    endfunction

    task automatic step();
        int ph, dg;
        bit on;
        logic [3:0] e_an_a, e_an_b;
        logic [6:0] e_seg_a, e_seg_b;
        logic e_dp_a, e_dp_b, e_serr;
        k++;
        ph = (k - 1) % SLOT;
        dg = ((k - 1) / SLOT) % N;
        on = (ph >= GUARD);
        e_serr = m_neg && (top_shown(m_dig, m_dp, blank_lz) == N - 1);
        if (on) begin
            e_an_a  = ~(4'b0001 << dg);
            e_an_b  = 4'b0001 << dg;
            e_seg_a = exp_seg(dg, 1'b1, m_dig, m_dp, m_neg, blank_lz);
            e_seg_b = ~exp_seg(dg, 1'b0, m_dig, m_dp, m_neg, blank_lz);
            e_dp_a  = ~m_dp[dg];
            e_dp_b  = m_dp[dg];
        end else begin
            e_an_a = 4'hF; e_an_b = 4'h0;
            e_seg_a = 7'h7F; e_seg_b = 7'h00;
            e_dp_a = 1'b1; e_dp_b = 1'b0;
        end
        @(posedge clk);
        if (load) begin
            m_dig = digits_in;
            m_dp  = dp_in;
            m_neg = neg_in;
        end
        #1;
        check_eq("an_a", 32'(an_a), 32'(e_an_a));
        check_eq("seg_a", 32'(seg_a), 32'(e_seg_a));
        check_eq("dp_a", 32'(dp_a), 32'(e_dp_a));
        check_eq("serr_a", 32'(serr_a), 32'(e_serr));
        check_eq("an_b", 32'(an_b), 32'(e_an_b));
        check_eq("seg_b", 32'(seg_b), 32'(e_seg_b));
        check_eq("dp_b", 32'(dp_b), 32'(e_dp_b));
        check_eq("serr_b", 32'(serr_b), 32'(e_serr));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic ng);
        digits_in = d;
        dp_in     = p;
        neg_in    = ng;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_an_a"}, 32'(an_a), 32'h0000_000F);
        check_eq({tag, "_seg_a"}, 32'(seg_a), 32'h0000_007F);
        check_eq({tag, "_dp_a"}, 32'(dp_a), 32'h1);
        check_eq({tag, "_serr_a"}, 32'(serr_a), 32'h0);
        check_eq({tag, "_an_b"}, 32'(an_b), 32'h0);
        check_eq({tag, "_seg_b"}, 32'(seg_b), 32'h0);
        check_eq({tag, "_dp_b"}, 32'(dp_b), 32'h0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear before the next edge
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        m_dig = '0; m_dp = '0; m_neg = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; digits_in = '0; dp_in = '0; neg_in = 1'b0; blank_lz = 1'b0;
        m_dig = '0; m_dp = '0; m_neg = 1'b0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        k   = 0;
        run(3);

        do_load(16'h1234, 4'b0000, 1'b0);
        run(24);

        blank_lz = 1'b1;
        do_load(16'h0042, 4'b0000, 1'b1);
        run(24);

        do_load(16'h9876, 4'b0000, 1'b1);
        run(22);
        do_load(16'h9876, 4'b0000, 1'b0);
        run(6);

        blank_lz = 1'b0;
        do_load(16'h00AF, 4'b0000, 1'b0);
        run(24);

        blank_lz = 1'b1;
        do_load(16'h0005, 4'b0100, 1'b1);
        run(22);
        do_load(16'h0000, 4'b0000, 1'b1);
        run(22);

        run(7);
        mid_reset();
        run(12);

        for (int it = 0; it < 250; it++) begin
            logic [15:0] d;
            logic [3:0]  p;
            for (int j = 0; j < N; j++) begin
                d[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                p[j]        = ($urandom_range(0, 7) == 0);
            end
            if ($urandom_range(0, 5) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 2) == 0) do_load(d, p, 1'($urandom_range(0, 1)));
            run($urandom_range(1, 8));
            if ($urandom_range(0, 59) == 0) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
